// File: rtl/note_pkg.sv
// note_pkg: note codes, pitch windows and FSM states shared by the note detector.
package note_pkg;
   localparam int NOTE_NONE = 0;
   localparam int NUM_NOTES = 13;
   localparam int TOL_SHIFT = 6;
   localparam int unsigned NOTE_NOM [1:NUM_NOTES] = '{59726, 56374, 53210, 50222, 47402, 44742, 42234,
                                                     39862, 37626, 35514, 33522, 31638, 29862};
   function automatic int unsigned note_bound(input int k, input bit hi);
      return hi ? NOTE_NOM[k] + (NOTE_NOM[k] >> TOL_SHIFT) : NOTE_NOM[k] - (NOTE_NOM[k] >> TOL_SHIFT);
   endfunction
   localparam int unsigned NOTE_LO [1:NUM_NOTES] = '{note_bound(1, 0), note_bound(2, 0), note_bound(3, 0),
      note_bound(4, 0), note_bound(5, 0), note_bound(6, 0), note_bound(7, 0), note_bound(8, 0),
      note_bound(9, 0), note_bound(10, 0), note_bound(11, 0), note_bound(12, 0), note_bound(13, 0)};
   localparam int unsigned NOTE_HI [1:NUM_NOTES] = '{note_bound(1, 1), note_bound(2, 1), note_bound(3, 1),
      note_bound(4, 1), note_bound(5, 1), note_bound(6, 1), note_bound(7, 1), note_bound(8, 1),
      note_bound(9, 1), note_bound(10, 1), note_bound(11, 1), note_bound(12, 1), note_bound(13, 1)};
   typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/note_classify.sv
// note_classify: maps a measured period to a note code, 0 when no window matches.
module note_classify
   import note_pkg::*;
#(
   parameter int PERIOD_W = 20
) (
   input  logic [PERIOD_W-1:0] p,
   output logic [3:0]          code
);
   logic [PERIOD_W:0] pe;
   assign pe = {1'b0, p};
   // windows never overlap, so scanning downward leaves the lowest matching code
   always_comb begin
      code = 4'(NOTE_NONE);
      for (int k = NUM_NOTES; k >= 1; k--)
         if (pe >= (PERIOD_W+1)'(NOTE_LO[k]) && pe <= (PERIOD_W+1)'(NOTE_HI[k]))
            code = 4'(k);
   end
endmodule

// File: rtl/note_detector.sv
// note_detector: measures the spacing of rising edges on tone_in and reports a
// debounced note code, the last period and a pulse on every note change.
module note_detector
   import note_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MATCH_COUNT = 3,
   parameter int TIMEOUT     = 131072,
   parameter int PERIOD_W    = 20
) (
   input  logic                clk_125mhz,
   input  logic                reset,
   input  logic                tone_in,
   output logic [7:0]          note,
   output logic [PERIOD_W-1:0] period,
   output logic                irq
);
   localparam int MW = $clog2(MATCH_COUNT + 1);
   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_prev, rise, valid;
   logic [PERIOD_W-1:0]    count;
   logic [3:0]             code, cand, note_r;
   logic [MW-1:0]          match, next_match;

   assign rise = sync[SYNC_STAGES-1] & ~sync_prev;
   assign note = {4'b0, note_r};
   assign next_match = (code != cand) ? MW'(1) : (match == MW'(MATCH_COUNT)) ? match : match + MW'(1);

   note_classify #(.PERIOD_W(PERIOD_W)) u_classify (.p(period), .code(code));

   // valid marks the cycle after a period is registered, when its code is debounced
   always_ff @(posedge clk_125mhz or posedge reset)
      if (reset) begin
         state     <= IDLE;
         sync      <= '0;
         sync_prev <= 1'b0;
         count     <= '0;
         valid     <= 1'b0;
         period    <= '0;
         cand      <= '0;
         match     <= '0;
         note_r    <= '0;
         irq       <= 1'b0;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], tone_in};
         sync_prev <= sync[SYNC_STAGES-1];
         valid     <= 1'b0;
         irq       <= 1'b0;
         if (state == IDLE) begin
            count <= '0;
            if (rise) state <= MEASURE;
         end else if (rise) begin
            period <= count + PERIOD_W'(1);
            count  <= '0;
            valid  <= 1'b1;
         end else if (count == PERIOD_W'(TIMEOUT - 1)) begin
            period <= PERIOD_W'(TIMEOUT);
            count  <= '0;
            state  <= IDLE;
            cand   <= '0;
            match  <= '0;
            note_r <= '0;
            irq    <= (note_r != '0);
         end else
            count <= count + PERIOD_W'(1);
         if (valid) begin
            cand  <= code;
            match <= next_match;
            if (next_match == MW'(MATCH_COUNT) && code != note_r) begin
               note_r <= code;
               irq    <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: drives square waves on tone_in; a reference model queues the
// expected period and note changes, and a negedge monitor checks them when due.
module tb_note_detector;
   localparam int SYNC    = 2;
   localparam int TIMEOUT = 131072;
   localparam int PW      = 20;
   typedef struct {int due; int val;} ev_t;

   logic          clk_125mhz = 1'b0;
   logic          reset = 1'b1;
   logic          tone_in = 1'b0;
   logic [7:0]    note;
   logic [PW-1:0] period;
   logic          irq;

   int  cyc = 0, n_checks = 0, n_fail = 0, cur_note = 0;
   ev_t pq[$], nq[$];
   bit  m_active = 1'b0;
   int  m_last = 0, m_cand = 0, m_cnt = 0, m_note = 0;
   int  hval[13] = '{14931, 14093, 13302, 12555, 11850, 11185, 10558, 9965, 9406, 8878, 8380, 7909, 7465};

   note_detector #(.SYNC_STAGES(SYNC), .MATCH_COUNT(3), .TIMEOUT(TIMEOUT), .PERIOD_W(PW)) dut (
      .clk_125mhz(clk_125mhz),
      .reset(reset),
      .tone_in(tone_in),
      .note(note),
      .period(period),
      .irq(irq)
   );

   always #4 clk_125mhz = ~clk_125mhz;
   always @(posedge clk_125mhz) cyc <= cyc + 1;

   always @(negedge clk_125mhz) begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
         n_checks++;
         if (period !== PW'(pq[0].val)) begin
            n_fail++;
            $display("FAIL period @%0d: got %0d, want %0d", cyc, period, pq[0].val);
         end
         void'(pq.pop_front());
      end
      if (nq.size() > 0 && nq[0].due == cyc) begin
         n_checks++;
         if (irq !== 1'b1 || note !== 8'(nq[0].val)) begin
            n_fail++;
            $display("FAIL note_change @%0d: got note=%0d irq=%b, want note=%0d irq=1", cyc, note, irq, nq[0].val);
         end
         cur_note = nq[0].val;
         void'(nq.pop_front());
      end else begin
         n_checks++;
         if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_irq @%0d: got irq=%b, want 0", cyc, irq);
         end
      end
      n_checks++;
      if (note !== 8'(cur_note)) begin
         n_fail++;
         $display("FAIL note_stable @%0d: got %0d, want %0d", cyc, note, cur_note);
      end
   end

   function automatic int classify(input int p);
      for (int k = 0; k < 13; k++) begin
         int nom = 4 * hval[k] + 2;
         int d = (p > nom) ? p - nom : nom - p;
         if (d <= (nom >> 6)) return k + 1;
      end
      return 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_125mhz);
      #1;
   endtask

   task automatic model_clear();
      m_active = 1'b0;
      m_cand   = 0;
      m_cnt    = 0;
      m_note   = 0;
   endtask

   task automatic rise_model();
      int p, code;
      if (m_active) begin
         p = cyc - m_last;
         pq.push_back('{cyc + SYNC + 1, p});
         code = classify(p);
         if (code == m_cand) begin
            if (m_cnt < 3) m_cnt++;
         end else begin
            m_cand = code;
            m_cnt  = 1;
         end
         if (m_cnt == 3 && m_cand != m_note) begin
            m_note = m_cand;
            nq.push_back('{cyc + SYNC + 2, m_note});
         end
      end
      m_active = 1'b1;
      m_last   = cyc;
   endtask

   task automatic wave(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         tone_in = 1'b1;
         rise_model();
         tick(p / 2);
         tone_in = 1'b0;
         tick(p - p / 2);
      end
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (pq.size() + nq.size() != 0) begin
         n_fail++;
         $display("FAIL %s drained: got %0d pending events, want 0", name, pq.size() + nq.size());
      end
   endtask

   task automatic test_reset();
      tick(5);
      n_checks++;
      if (note !== 8'd0) begin n_fail++; $display("FAIL reset note: got %0d, want 0", note); end
      n_checks++;
      if (period !== '0) begin n_fail++; $display("FAIL reset period: got %0d, want 0", period); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset irq: got %b, want 0", irq); end
      reset = 1'b0;
      tick(5);
   endtask

   task automatic test_note1();
      wave(59726, 4);
      check_drained("note1");
   endtask

   task automatic test_switch();
      wave(29862, 4);
      check_drained("switch");
   endtask

   task automatic test_out_of_range();
      wave(60726, 4);
      check_drained("out_of_range");
   endtask

   task automatic test_timeout();
      wave(39862, 4);
      pq.push_back('{m_last + SYNC + 1 + TIMEOUT, TIMEOUT});
      if (m_note != 0) nq.push_back('{m_last + SYNC + 1 + TIMEOUT, 0});
      model_clear();
      tick(TIMEOUT);
      check_drained("timeout");
   endtask

   task automatic test_alternating();
      for (int i = 0; i < 6; i++) wave((i % 2) ? 33522 : 35514, 1);
      check_drained("alternating");
   endtask

   task automatic test_reset_mid_period();
      wave(47402, 4);
      tick(100);
      check_drained("pre_reset");
      reset = 1'b1;
      model_clear();
      cur_note = 0;
      #1;
      n_checks++;
      if (note !== 8'd0) begin n_fail++; $display("FAIL midreset note: got %0d, want 0", note); end
      n_checks++;
      if (period !== '0) begin n_fail++; $display("FAIL midreset period: got %0d, want 0", period); end
      tick(3);
      reset = 1'b0;
      tick(3);
      wave(1000, 1);
      n_checks++;
      if (period !== '0) begin n_fail++; $display("FAIL start_edge period: got %0d, want 0", period); end
      wave(1000, 1);
      tick(10);
      check_drained("post_reset");
   endtask

   initial begin
      test_reset();
      test_note1();
      test_switch();
      test_out_of_range();
      test_timeout();
      test_alternating();
      test_reset_mid_period();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
